// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_W = 32;

    // Operation codes, sampled with start.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Signed operations take magnitudes; unsigned ones pass through.
    function automatic logic op_is_signed(input md_op_e o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    // Two's-complement magnitude. 0x80000000 maps to itself, which the
    // unsigned datapath reads correctly as 2^31.
    function automatic logic [MD_W-1:0] mag32(input logic [MD_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO
// registers. One result bit per clock: 32 CALC cycles plus one FIX cycle.
import muldiv_unit_pkg::*;

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state;
    md_op_e           op_reg;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic [5:0]       cnt;
    // {carry, HI accumulator / partial remainder, LO shift register}
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opb;

    md_op_e           op_in;
    logic             in_signed;
    logic             in_sa;
    logic             in_sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_next;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH+1:0] div_trial;
    logic             div_ok;
    logic [2*WIDTH:0] div_next;

    logic             is_mul;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op_in     = md_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_sa     = in_signed & a[WIDTH-1];
    assign in_sb     = in_signed & b[WIDTH-1];
    assign a_mag     = mag32(a, in_sa);
    assign b_mag     = mag32(b, in_sb);
    assign is_mul    = (op_reg == MD_MULT) || (op_reg == MD_MULTU);

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
        div_rem   = acc[2*WIDTH-1:WIDTH-1];
        div_trial = {1'b0, div_rem} - {2'b00, opb};
        div_ok    = ~div_trial[WIDTH+1];
        div_next  = {(div_ok ? div_trial[WIDTH:0] : div_rem), acc[WIDTH-2:0], div_ok};
    end

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prod_fix = (op_reg == MD_MULT && (sign_a ^ sign_b)) ? (~acc[2*WIDTH-1:0] + 1'b1)
                                                             : acc[2*WIDTH-1:0];
        quot_fix = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (b_zero) begin
            quot_fix = {WIDTH{1'b1}};
        end
    end

    // Control FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MD_IDLE;
            op_reg <= MD_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Start wins over a simultaneous MTHI/MTLO.
                        op_reg <= op_in;
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        b_zero <= (b == '0);
                        acc    <= {{(WIDTH+1){1'b0}}, a_mag};
                        opb    <= b_mag;
                        cnt    <= 6'd31;
                        busy   <= 1'b1;
                        state  <= MD_CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MD_CALC: begin
                    acc <= is_mul ? mul_next : div_next;
                    if (cnt == 6'd0) begin
                        state <= MD_FIX;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                MD_FIX: begin
                    if (is_mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;
    logic        start = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Reference: architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sq, sr;
        case (o)
            2'd0: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {sr, sq};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Launch one operation and follow it to done, checking timing and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input bit mt_with_start);
        logic [63:0] r;
        int  busy_cnt;
        bit  got;
        r = model(o, x, y);
        @(negedge clk);
        a = x; b = y; op = o; start = 1'b1;
        if (mt_with_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        end
        busy_cnt = 0;
        got = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                a = $urandom; b = $urandom;
                check("hi_held_at_start", {32'd0, hi}, {32'd0, exp_hi});
                check("lo_held_at_start", {32'd0, lo}, {32'd0, exp_lo});
            end
            if (disturb && k == 10) begin
                start = 1'b1; op = 2'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (disturb && k == 11) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = 1;
                check("done_cycle", 64'(k), 64'd34);
                check("busy_with_done", {63'd0, busy}, 64'd0);
                check("hi_result", {32'd0, hi}, {32'd0, r[63:32]});
                check("lo_result", {32'd0, lo}, {32'd0, r[31:0]});
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", o, x, y, hi, lo);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    // MTHI/MTLO in IDLE, visible on the following cycle.
    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] v);
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = v;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) exp_hi = v;
        if (wl) exp_lo = v;
        check("mt_hi", {32'd0, hi}, {32'd0, exp_hi});
        check("mt_lo", {32'd0, lo}, {32'd0, exp_lo});
        $display("mt hi_we=%0d lo_we=%0d wdata=0x%08h -> hi=0x%08h lo=0x%08h", wh, wl, v, hi, lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          done_seen;

        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'd3, 32'd100, 32'd7, 0, 0);
        run_op(2'd3, 32'h64, 32'd0, 0, 0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 0);

        // Writes to HI first so the ignored mid-CALC MTHI would be visible.
        mt_write(1, 0, 32'h0BAD_F00D);
        run_op(2'd1, 32'd3, 32'd4, 1, 0);
        mt_write(0, 1, 32'hA5A5_A5A5);
        mt_write(1, 1, 32'h5A5A_0F0F);
        run_op(2'd1, 32'd3, 32'd4, 0, 1);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, 0, 0);
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a = 32'd1234; b = 32'd5678; op = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        $display("reset mid-CALC -> busy=%0d done=%0d hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        @(negedge clk);
        rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        run_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the multicycle MIPS core. It sits directly downstream of the register file: it consumes the two read-port outputs (busa, busb) for MULT/MULTU/DIV/DIVU and holds the results in the architectural HI/LO registers. The control FSM reads HI/LO back for MFHI/MFLO. The unit computes one bit per clock, so the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  core clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `a`  in  32  operand A (rs, from regfile busa); dividend or multiplicand.
- `b`  in  32  operand B (rt, from regfile busb); divisor or multiplier.
- `op`  in  2  operation, sampled with `start`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `hi_we`  in  1  MTHI: write `wdata` to HI.
- `lo_we`  in  1  MTLO: write `wdata` to LO.
- `wdata`  in  32  MTHI/MTLO data (busa).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO are updated this cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1 at a clock edge:
  - Latch |a| and |b| (absolute values for signed ops, raw values for unsigned).
  - Latch sign flags and op; clear the accumulator.
  - Load the 6-bit counter with 31; go to CALC.
- CALC, multiply: 64-bit shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, 33-bit trial subtract.
- CALC runs exactly 32 cycles; when the counter reaches 0, go to FIX.
- FIX: apply sign correction and write HI/LO. Assert `done` for that cycle, then return to IDLE.
- Sign rules:
  - Product is negated iff sign(a)^sign(b) (signed MULT only).
  - Quotient is negated iff sign(a)^sign(b).
  - Remainder takes sign(a).
- Results:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (b=0): LO=0xFFFFFFFF, HI=a (raw dividend). Still takes the full latency.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the 32-bit unsigned magnitude path.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `hi_we`/`lo_we` while `busy`=1 are ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` is accepted and the writes are dropped.
- `hi_we` and `lo_we` together in IDLE: both registers get `wdata`.
- HI/LO change only in FIX or on an accepted MTHI/MTLO. A and B are not needed after the `start` edge.

## Timing
- Reset (async assert, any state) forces IDLE:
  - `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and datapath cleared.
  - Reset mid-operation aborts the operation with no HI/LO update.
- Deassertion is synchronised by the integrator; the first active edge after deassertion sees IDLE.
- Edge 0 accepts `start`. `busy`=1 from after edge 0 through edge 33.
- Edges 1..32 are CALC. Edge 33 is FIX: HI/LO are written and `done`=1 during the cycle after edge 33.
- `busy` falls together with the `done` rise (registered after edge 33), so `busy` and `done` are never high together.
- A new `start` can be accepted on the edge after FIX: back-to-back throughput is one operation per 34 cycles.
- MTHI/MTLO take effect on the accepting edge; the value is visible on `hi`/`lo` the next cycle.
- `hi`/`lo` are register outputs with no combinational path from inputs.

## Structure
- Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the state encoding go in global_def.v beside the existing opcode/funct defines.
- Single module; no sub-module required.
- The datapath is a 65-bit {carry, HI-accumulator, LO/shift} register shared by multiply and divide, plus a 32-bit operand-B register.

## Test plan
- Reset then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> `done` on cycle 34; HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=0x64 b=0 -> LO=0xFFFFFFFF, HI=0x64. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULTU 3*4, pulse `start` (DIVU) and `hi_we` mid-CALC -> both ignored; HI=0, LO=12 at `done`. Then MTLO wdata=0xA5A5A5A5 in IDLE -> `lo`=0xA5A5A5A5 next cycle.
- Assert `rst` low at CALC cycle 10 -> `busy`, `done`, `hi`, `lo` go 0 immediately (asynchronous); no `done` pulse follows; the next `start` completes normally.
